// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 tables, shift schedule, widths and the
// key-schedule helpers (permutation, C/D rotation, key-byte parity).
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;
    localparam int RIDX_W   = 4;

    // Table entries use DES numbering: 1 is the MSB of the source vector.
    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // S[1..16] stored at indices 0..15.
    localparam int SHIFT_TAB [ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_GEN  = 1'b1
    } ks_state_e;

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        for (int i = 0; i < CD_W; i++) begin
            cd[CD_W-1-i] = key[KEY_W - PC1_TAB[i]];
        end
        return cd;
    endfunction

    function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] h,
                                                   input logic right, input logic two);
        case ({right, two})
            2'b00:   return {h[HALF_W-2:0], h[HALF_W-1]};
            2'b01:   return {h[HALF_W-3:0], h[HALF_W-1 -: 2]};
            2'b10:   return {h[0], h[HALF_W-1:1]};
            default: return {h[1:0], h[HALF_W-1:2]};
        endcase
    endfunction

    // C and D rotate independently by the same amount.
    function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] cd,
                                               input logic right, input logic two);
        return {rot_half(cd[CD_W-1 -: HALF_W], right, two), rot_half(cd[HALF_W-1:0], right, two)};
    endfunction

    function automatic logic shift_is_two(input logic [RIDX_W-1:0] s_idx);
        return SHIFT_TAB[s_idx] == 2;
    endfunction

    function automatic logic key_parity_ok(input logic [KEY_W-1:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < KEY_W / 8; b++) begin
            ok = ok & (^key[8*b +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-offer / subkey-delivery bundle of the DES key schedule.
// master = key source and subkey consumer, slave = the key-schedule block.
interface des_key_schedule_if;
    import des_pkg::*;

    logic [KEY_W-1:0]    key_in;
    logic                decrypt;
    logic                key_valid;
    logic                key_ready;
    logic [SUBKEY_W-1:0] subkey;
    logic                subkey_valid;
    logic                subkey_ready;
    logic [RIDX_W-1:0]   round_idx;
    logic                done;
    logic                parity_err;

    modport master (
        output key_in, decrypt, key_valid, subkey_ready,
        input  key_ready, subkey, subkey_valid, round_idx, done, parity_err
    );

    modport slave (
        input  key_in, decrypt, key_valid, subkey_ready,
        output key_ready, subkey, subkey_valid, round_idx, done, parity_err
    );

endinterface

// File: rtl/des_pc2.sv
// Combinational DES PC-2 permutation (56-bit C/D -> 48-bit subkey),
// shared with the round datapath.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     cd,
    output logic [SUBKEY_W-1:0] subkey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_bit
        assign subkey[SUBKEY_W-1-i] = cd[CD_W - PC2_TAB[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one key in, sixteen subkeys out (K1..K16 or K16..K1).
// Optional key-byte odd-parity rejection when DES_KS_PARITY_CHECK_EN is defined.
module des_key_schedule
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    des_key_schedule_if.slave ks
);

    ks_state_e           state_q, state_d;
    logic [CD_W-1:0]     cd_q, cd_d;
    logic                mode_q, mode_d;
    logic [RIDX_W-1:0]   round_q, round_d;
    logic                done_q, done_d;
    logic                perr_q, perr_d;
    logic [CD_W-1:0]     key_cd;
    logic [SUBKEY_W-1:0] pc2_out;
    logic                key_bad;
    logic                last_round;
    logic                shift_two;

    des_pc2 u_pc2 (
        .cd     (cd_q),
        .subkey (pc2_out)
    );

    assign key_cd     = pc1(ks.key_in);
    assign last_round = (round_q == RIDX_W'(ROUNDS - 1));

    // Decrypt walks the schedule backwards, undoing S[16-r] each step.
    assign shift_two = mode_q ? shift_is_two(RIDX_W'(ROUNDS - 1) - round_q)
                              : shift_is_two(round_q + RIDX_W'(1));

`ifdef DES_KS_PARITY_CHECK_EN
    assign key_bad = !key_parity_ok(ks.key_in);
`else
    logic unused_parity_bits;
    assign key_bad            = 1'b0;
    assign unused_parity_bits = ^{ks.key_in[56], ks.key_in[48], ks.key_in[40], ks.key_in[32],
                                  ks.key_in[24], ks.key_in[16], ks.key_in[8],  ks.key_in[0]};
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cd_d    = cd_q;
        mode_d  = mode_q;
        round_d = round_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        case (state_q)
            KS_IDLE: begin
                if (ks.key_valid) begin
                    if (key_bad) begin
                        perr_d = 1'b1;
                    end else begin
                        // Encrypt preloads the K1 state; the raw PC-1 load is already K16.
                        state_d = KS_GEN;
                        mode_d  = ks.decrypt;
                        cd_d    = ks.decrypt ? key_cd : rot_cd(key_cd, 1'b0, 1'b0);
                        round_d = '0;
                    end
                end
            end
            KS_GEN: begin
                if (ks.subkey_ready) begin
                    if (last_round) begin
                        state_d = KS_IDLE;
                        round_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        cd_d    = rot_cd(cd_q, mode_q, shift_two);
                        round_d = round_q + RIDX_W'(1);
                    end
                end
            end
            default: state_d = KS_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KS_IDLE;
            cd_q    <= '0;
            mode_q  <= 1'b0;
            round_q <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            mode_q  <= mode_d;
            round_q <= round_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
        end
    end

    assign ks.key_ready    = (state_q == KS_IDLE);
    assign ks.subkey_valid = (state_q == KS_GEN);
    assign ks.subkey       = (state_q == KS_GEN) ? pc2_out : '0;
    assign ks.round_idx    = round_q;
    assign ks.done         = done_q;
    assign ks.parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: stimulus queues expected subkeys,
// a negedge monitor pops and compares on every subkey handshake.
module tb_des_key_schedule;
    import des_pkg::*;

    typedef struct packed {
        logic [SUBKEY_W-1:0] key;
        logic [RIDX_W-1:0]   idx;
    } exp_t;

    localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BADP = 64'h133457799BBCDFF0;

    // Textbook subkeys of KEY_GOOD, K1..K16.
    localparam logic [47:0] ENC_KEYS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    des_key_schedule_if ks_bus ();

    des_key_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks_bus)
    );

    exp_t                sb_q [$];
    int                  n_cmp      = 0;
    int                  n_fail     = 0;
    int                  hs_count   = 0;
    bit                  expect_done  = 1'b0;
    bit                  stalled_prev = 1'b0;
    logic [SUBKEY_W-1:0] prev_key;
    logic [RIDX_W-1:0]   prev_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("ready_valid_exclusive", 64'(ks_bus.key_ready & ks_bus.subkey_valid), 64'd0);
            check("done_pulse", 64'(ks_bus.done), 64'(expect_done));
            if (expect_done) check("key_ready_at_done", 64'(ks_bus.key_ready), 64'd1);
            expect_done = 1'b0;
            if (stalled_prev) begin
                check("stall_valid_hold", 64'(ks_bus.subkey_valid), 64'd1);
                check("stall_subkey_hold", 64'(ks_bus.subkey), 64'(prev_key));
                check("stall_idx_hold", 64'(ks_bus.round_idx), 64'(prev_idx));
            end
            stalled_prev = ks_bus.subkey_valid && !ks_bus.subkey_ready;
            prev_key     = ks_bus.subkey;
            prev_idx     = ks_bus.round_idx;
            if (!ks_bus.subkey_valid) check("subkey_zero_when_invalid", 64'(ks_bus.subkey), 64'd0);
            if (ks_bus.subkey_valid && ks_bus.subkey_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_subkey: got 0x%0h, required no subkey", ks_bus.subkey);
                end else begin
                    e = sb_q.pop_front();
                    check("subkey", 64'(ks_bus.subkey), 64'(e.key));
                    check("round_idx", 64'(ks_bus.round_idx), 64'(e.idx));
                    if (e.idx == 4'd15) expect_done = 1'b1;
                end
                hs_count++;
            end
        end else begin
            stalled_prev = 1'b0;
            expect_done  = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic offer_key(input logic [63:0] key, input logic dec, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ks_bus.key_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            bound_fail("key_ready_wait");
            return;
        end
        ks_bus.key_in    = key;
        ks_bus.decrypt   = dec;
        ks_bus.key_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs: they must only matter at acceptance.
        ks_bus.key_valid = 1'b0;
        ks_bus.decrypt   = ~dec;
        ks_bus.key_in    = ~key;
    endtask

    task automatic push_schedule(input logic dec);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.key = dec ? ENC_KEYS[15-i] : ENC_KEYS[i];
            e.idx = 4'(i);
            sb_q.push_back(e);
        end
    endtask

    task automatic run_sched(input logic [63:0] key, input logic dec, input bit bp, input bit ghost);
        int base;
        int cycles;
        bit seen_done;
        bit ok;
        base      = hs_count;
        cycles    = 0;
        seen_done = 1'b0;
        push_schedule(dec);
        offer_key(key, dec, ok);
        if (!ok) begin
            sb_q.delete();
            return;
        end
        for (int c = 1; c <= 200 && !seen_done; c++) begin
            ks_bus.subkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ghost && ks_bus.subkey_valid) begin
                ks_bus.key_valid = 1'($urandom_range(0, 1));
                ks_bus.key_in    = {$urandom(), $urandom()};
                ks_bus.decrypt   = 1'($urandom_range(0, 1));
            end else begin
                ks_bus.key_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 1) check("valid_at_T1", 64'(ks_bus.subkey_valid), 64'd1);
            if (ks_bus.done) begin
                seen_done = 1'b1;
                cycles    = c;
            end
            @(posedge clk);
            #1;
        end
        ks_bus.key_valid    = 1'b0;
        ks_bus.subkey_ready = 1'b1;
        if (!seen_done) begin
            bound_fail("done_wait");
            sb_q.delete();
        end
        if (!bp) check("done_latency", 64'(cycles), 64'd17);
        check("handshake_count", 64'(hs_count - base), 64'd16);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, 64'(ks_bus.key_ready), 64'd1);
        check({tag, "_subkey_valid"}, 64'(ks_bus.subkey_valid), 64'd0);
        check({tag, "_subkey"}, 64'(ks_bus.subkey), 64'd0);
        check({tag, "_round_idx"}, 64'(ks_bus.round_idx), 64'd0);
        check({tag, "_done"}, 64'(ks_bus.done), 64'd0);
        check({tag, "_parity_err"}, 64'(ks_bus.parity_err), 64'd0);
    endtask

    task automatic reset_mid();
        int base;
        bit ok;
        base = hs_count;
        push_schedule(1'b0);
        ks_bus.subkey_ready = 1'b1;
        offer_key(KEY_GOOD, 1'b0, ok);
        for (int c = 0; c < 100 && (hs_count - base) < 5; c++) begin
            @(posedge clk);
            #1;
        end
        check("handshakes_before_reset", 64'(hs_count - base), 64'd5);
        check("round_idx_before_reset", 64'(ks_bus.round_idx), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        sb_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ks_bus.key_in       = '0;
        ks_bus.decrypt      = 1'b0;
        ks_bus.key_valid    = 1'b0;
        ks_bus.subkey_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_sched(KEY_GOOD, 1'b0, 1'b0, 1'b0);   // encrypt K1..K16
        run_sched(KEY_GOOD, 1'b1, 1'b0, 1'b0);   // decrypt K16..K1
        run_sched(KEY_GOOD, 1'b0, 1'b1, 1'b1);   // random stalls, stray key offers
        reset_mid();
        run_sched(KEY_GOOD, 1'b0, 1'b0, 1'b0);   // fresh key after reset

`ifdef DES_KS_PARITY_CHECK_EN
        begin
            bit ok;
            offer_key(KEY_BADP, 1'b0, ok);
            @(negedge clk);
            check("parity_err_pulse", 64'(ks_bus.parity_err), 64'd1);
            check("parity_no_valid", 64'(ks_bus.subkey_valid), 64'd0);
            check("parity_key_ready", 64'(ks_bus.key_ready), 64'd1);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("parity_err_cleared", 64'(ks_bus.parity_err), 64'd0);
            check("parity_still_idle", 64'(ks_bus.subkey_valid), 64'd0);
            @(posedge clk);
            #1;
        end
`else
        run_sched(KEY_BADP, 1'b0, 1'b0, 1'b0);   // parity bits ignored
        check("parity_err_tied_low", 64'(ks_bus.parity_err), 64'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key-schedule generator that turns one 64-bit key into the sixteen 48-bit round subkeys. It emits them one per handshake, in encryption order (K1..K16) or in decryption order (K16..K1). The decryption order is produced by right-rotating C/D, not by buffering all sixteen subkeys. The block sits beside the round datapath, between `initial_permutation` and `final_permutation`, and feeds the round function its subkey. It is the inverse-direction partner of the encrypt path, and 3DES reuses one instance per stage.

## Interface
Parameters:
- none; all table widths and constants come from `des_pkg`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_in`  in  64  DES key; DES bit 1 = `key_in[63]`; parity bits 8, 16, …, 64 are dropped by PC-1.
- `decrypt`  in  1  0 = emit K1→K16, 1 = emit K16→K1; sampled only at key acceptance.
- `key_valid`  in  1  key offer.
- `key_ready`  out  1  high only in IDLE; the key is accepted on `key_valid & key_ready`.
- `subkey`  out  48  current round subkey, PC-2 order (DES bit 1 = `subkey[47]`); 0 when `subkey_valid` = 0.
- `subkey_valid`  out  1  `subkey` is valid.
- `subkey_ready`  in  1  consumer takes the subkey on `subkey_valid & subkey_ready`.
- `round_idx`  out  4  index of the presented subkey, 0..15 in emission order.
- `done`  out  1  one-cycle pulse in the cycle after the 16th subkey handshake.
- `parity_err`  out  1  one-cycle pulse on a rejected key (see Configuration).

## Operation
- States:
  - IDLE: `key_ready` = 1.
  - GEN: `subkey_valid` = 1.
- IDLE→GEN on key acceptance:
  - the 56-bit C/D register is loaded with PC-1(`key_in`);
  - in encrypt mode the load is pre-rotated left by 1, so it already holds the K1 state;
  - in decrypt mode it is loaded unrotated, which is the K16 state (total shift is 28);
  - `decrypt` is latched into `mode`.
- Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- `subkey` = PC-2(C/D), computed combinationally from the register.
- On each subkey handshake with `round_idx` = r < 15:
  - encrypt: C and D each rotate left by S[r+2];
  - decrypt: C and D each rotate right by S[16−r];
  - `round_idx` increments.
- On the handshake with `round_idx` = 15: go to IDLE, clear `round_idx`, pulse `done`.
- `subkey_valid` && !`subkey_ready`: C/D, `subkey` and `round_idx` hold stable (no drop, no skip).
- `key_valid` is ignored while in GEN; there is no abort path.
- Async reset at any point, including mid-schedule: immediately IDLE. Reset values:
  - `key_ready` = 1;
  - `subkey_valid` = 0, `subkey` = 0, `round_idx` = 0;
  - `done` = 0, `parity_err` = 0;
  - C/D = 0, `mode` = 0.

## Timing
- Key accepted at edge T → `subkey_valid` = 1 with K(first) from T+1.
- With `subkey_ready` held at 1:
  - 16 subkeys appear on 16 consecutive cycles, T+1..T+16;
  - `done` = 1 and `key_ready` = 1 at T+17.
- Back-to-back keys: the earliest next acceptance is at the edge ending cycle T+17, so the minimum key period is 17 cycles.
- `key_ready` and `subkey_valid` are mutually exclusive in every cycle.

## Configuration
- `DES_KS_PARITY_CHECK_EN` defined:
  - at acceptance, each key byte is checked for odd parity;
  - on any failing byte, the key is consumed (handshake completes) but the block stays in IDLE and pulses `parity_err` the next cycle;
  - no subkeys are emitted for that key.
- `DES_KS_PARITY_CHECK_EN` undefined:
  - no check is performed; `parity_err` is tied to 0;
  - every accepted key is scheduled.

## Structure
- `des_pkg` holds:
  - PC-1 table (56 entries) and PC-2 table (48 entries);
  - shift schedule S[1..16];
  - width constants (KEY_W = 64, CD_W = 56, SUBKEY_W = 48, ROUNDS = 16).
- Sub-module `des_pc2`: purely combinational 56→48 PC-2 permutation, reused by the round datapath.
- PC-1 is instantiated inline.

## Test plan
- Encrypt:
  - stimulus: key 0x133457799BBCDFF1, `decrypt` = 0, `subkey_ready` = 1;
  - response: T+1 `subkey` = 0x1B02EFFC7072 with `round_idx` 0; T+16 `subkey` = 0xCB3D8B0E17F5 with `round_idx` 15; `done` at T+17.
- Decrypt:
  - stimulus: same key with `decrypt` = 1;
  - response: T+1 `subkey` = 0xCB3D8B0E17F5; final subkey 0x1B02EFFC7072; all 16 subkeys equal the encrypt list reversed.
- Backpressure:
  - stimulus: `subkey_ready` toggled randomly during encrypt;
  - response: identical 16-value sequence; outputs stable while stalled; `key_valid` pulses during GEN are ignored.
- Reset mid-operation:
  - stimulus: drop `rst_n` after the 5th handshake;
  - response: outputs go to their reset values immediately; a fresh key after reset restarts at `round_idx` 0 with the correct K1.
- Parity (macro defined):
  - stimulus: key 0x133457799BBCDFF0 (last byte has even parity);
  - response: `parity_err` pulse at T+1; `subkey_valid` stays 0; `key_ready` stays 1.
- Parity (macro undefined):
  - stimulus: the same key;
  - response: subkeys identical to those of 0x133457799BBCDFF1, since parity bits are ignored.
